adc_cordic_sched: RTL and testbench

ADC_CORDIC_SCHED -- requirements
Module: adc_cordic_sched

---
 rtl/adc_sched_pkg.sv | 36 +++
 rtl/sched_result_fifo.sv | 65 ++++++
 rtl/adc_cordic_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_adc_cordic_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// Shared definitions for the ADC/CORDIC scheduler: register map, bit positions, FSM encoding.
package adc_sched_pkg;

  // Register offsets as seen on PADDR[3:2]
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PERIOD = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RESULT = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_START_BIT  = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;
  localparam int unsigned STAT_FULL_BIT  = 2;
  localparam int unsigned STAT_OVF_BIT   = 3;
  localparam int unsigned STAT_MISS_BIT  = 4;

  // Conversion sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STORE  = 3'd4
  } sched_state_e;

  // Even parity over a 32-bit word, used when protecting register images
  function automatic logic parity32(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/sched_result_fifo.sv
// Result FIFO: circular buffer with occupancy count; a pop on a full FIFO frees room for a same-cycle push.
module sched_result_fifo
  import adc_sched_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify push/pop against occupancy
  always_comb begin
    pop_ok_s  = pop & (count_r != CW'(0));
    push_ok_s = push & ((count_r != CW'(DEPTH)) | pop_ok_s);
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, cleared on reset so nothing stale is ever presented
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
  assign count = count_r;

endmodule

// File: rtl/adc_cordic_sched.sv
// Periodic ADC sampler that feeds a CORDIC unit and queues {sample, result} pairs behind an APB register file.
module adc_cordic_sched
  import adc_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int CORDIC_LAT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [7:0]            PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic [DATA_WIDTH-1:0] cordic_in,
  output logic                  cordic_wr,
  input  logic [DATA_WIDTH-1:0] cordic_out,
  output logic                  irq
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W = $clog2(CORDIC_LAT + 1);

  // Bus decode
  logic       access_s, mapped_s, wr_s, rd_s, start_s, pop_s;
  logic [1:0] offset_s;

  // Registers
  logic        en_r, irq_en_r, ovf_r, miss_r;
  logic [15:0] period_r;
  logic [15:0] tmr_cnt_r;
  logic        tmr_run_r;
  logic        tmr_trig_s, trigger_s;

  // Sequencer
  sched_state_e          state_r, state_next_s;
  logic [WAIT_W-1:0]     wait_cnt_r;
  logic [DATA_WIDTH-1:0] sample_r;
  logic                  cordic_wr_r;
  logic                  push_s;

  // FIFO
  logic [2*DATA_WIDTH-1:0] fifo_rdata_s;
  logic                    fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]        fifo_count_s;

  logic [31:0] prdata_s;
  logic        unused_s;

  // APB decode: only offsets 0x0..0xC are mapped, higher address bits flag an error
  always_comb begin
    access_s = PSEL & PENABLE;
    mapped_s = (PADDR[7:4] == 4'd0);
    offset_s = PADDR[3:2];
    wr_s     = access_s & PWRITE & mapped_s;
    rd_s     = access_s & ~PWRITE & mapped_s;
    start_s  = wr_s & (offset_s == OFF_CTRL) & PWDATA[CTRL_START_BIT];
    pop_s    = rd_s & (offset_s == OFF_RESULT);
  end

  // Trigger sources: period timer expiry or a software START
  always_comb begin
    tmr_trig_s = tmr_run_r & (tmr_cnt_r == 16'd0) & en_r & (period_r != 16'd0);
    trigger_s  = tmr_trig_s | start_s;
  end

  // Control and period registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r     <= 1'b0;
      irq_en_r <= 1'b0;
      period_r <= 16'd0;
    end else if (wr_s) begin
      case (offset_s)
        OFF_CTRL: begin
          en_r     <= PWDATA[CTRL_EN_BIT];
          irq_en_r <= PWDATA[CTRL_IRQ_EN_BIT];
        end
        OFF_PERIOD: period_r <= PWDATA[15:0];
        default: ;
      endcase
    end
  end

  // Period counter: first cycle after enable loads PERIOD-1, then counts down and reloads at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_cnt_r <= 16'd0;
      tmr_run_r <= 1'b0;
    end else if (!en_r || (period_r == 16'd0)) begin
      tmr_cnt_r <= 16'd0;
      tmr_run_r <= 1'b0;
    end else if (!tmr_run_r) begin
      tmr_cnt_r <= period_r - 16'd1;
      tmr_run_r <= 1'b1;
    end else if (tmr_cnt_r == 16'd0) begin
      tmr_cnt_r <= period_r - 16'd1;
    end else begin
      tmr_cnt_r <= tmr_cnt_r - 16'd1;
    end
  end

  // Sticky miss/overflow flags; a new event in the same cycle as the clear keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      if (trigger_s && (state_r != ST_IDLE)) begin
        miss_r <= 1'b1;
      end else if (wr_s && (offset_s == OFF_STATUS) && PWDATA[STAT_MISS_BIT]) begin
        miss_r <= 1'b0;
      end
      if (push_s && fifo_full_s && !pop_s) begin
        ovf_r <= 1'b1;
      end else if (wr_s && (offset_s == OFF_STATUS) && PWDATA[STAT_OVF_BIT]) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (trigger_s) state_next_s = ST_SAMPLE;
        else           state_next_s = ST_IDLE;
      end
      ST_SAMPLE: state_next_s = ST_ISSUE;
      ST_ISSUE:  state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_W'(CORDIC_LAT - 1)) state_next_s = ST_STORE;
        else                                       state_next_s = ST_WAIT;
      end
      ST_STORE:  state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // Sequencer datapath: sample capture, latency counter, registered start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_r    <= '0;
      wait_cnt_r  <= WAIT_W'(0);
      cordic_wr_r <= 1'b0;
    end else begin
      cordic_wr_r <= (state_next_s == ST_ISSUE);
      if (state_r == ST_SAMPLE) sample_r <= adc_data;
      if (state_r == ST_WAIT) wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      else                    wait_cnt_r <= WAIT_W'(0);
    end
  end

  assign push_s = (state_r == ST_STORE);

  sched_result_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({sample_r, cordic_out}),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Read mux; RESULT reads zero when nothing is queued
  always_comb begin
    prdata_s = 32'd0;
    if (mapped_s) begin
      case (offset_s)
        OFF_CTRL: begin
          prdata_s[CTRL_EN_BIT]     = en_r;
          prdata_s[CTRL_IRQ_EN_BIT] = irq_en_r;
        end
        OFF_PERIOD: prdata_s[15:0] = period_r;
        OFF_STATUS: begin
          prdata_s[STAT_BUSY_BIT]  = (state_r != ST_IDLE);
          prdata_s[STAT_EMPTY_BIT] = fifo_empty_s;
          prdata_s[STAT_FULL_BIT]  = fifo_full_s;
          prdata_s[STAT_OVF_BIT]   = ovf_r;
          prdata_s[STAT_MISS_BIT]  = miss_r;
          prdata_s[7:5]            = 3'(fifo_count_s);
        end
        OFF_RESULT: begin
          if (!fifo_empty_s) begin
            prdata_s = (32'(fifo_rdata_s[2*DATA_WIDTH-1:DATA_WIDTH]) << 16) |
                       32'(fifo_rdata_s[DATA_WIDTH-1:0]);
          end else begin
            prdata_s = 32'd0;
          end
        end
        default: prdata_s = 32'd0;
      endcase
    end else begin
      prdata_s = 32'd0;
    end
  end

  assign PRDATA    = prdata_s;
  assign PREADY    = 1'b1;
  assign PSLVERR   = access_s & ~mapped_s;
  assign cordic_in = sample_r;
  assign cordic_wr = cordic_wr_r;
  assign irq       = irq_en_r & ~fifo_empty_s;
  assign unused_s  = ^{PADDR[1:0], PWDATA[31:16]};

endmodule

// File: tb/tb_adc_cordic_sched.sv
// Directed bench for adc_cordic_sched with a behavioural CORDIC (result = operand ^ 0x575 after CORDIC_LAT cycles).
module tb_adc_cordic_sched;

  localparam int DW  = 12;
  localparam int LAT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]    paddr = 8'd0;
  logic [31:0]   pwdata = 32'd0;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic [DW-1:0] adc_data = 12'd0;
  logic [DW-1:0] cordic_in;
  logic          cordic_wr;
  logic [DW-1:0] cordic_out = 12'd0;
  logic          irq;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int lat_cnt  = 0;
  logic [DW-1:0] pend = 12'd0;

  adc_cordic_sched #(.DATA_WIDTH(DW), .CORDIC_LAT(LAT), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .adc_data(adc_data), .cordic_in(cordic_in), .cordic_wr(cordic_wr),
    .cordic_out(cordic_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter and start-pulse counter
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    wr_cnt <= wr_cnt + (cordic_wr ? 1 : 0);
  end

  // CORDIC model: output is poisoned on start, valid LAT cycles after cordic_wr, then held
  always @(posedge clk) begin
    if (rst) begin
      lat_cnt    <= 0;
      cordic_out <= 12'd0;
    end else if (cordic_wr) begin
      lat_cnt    <= LAT - 1;
      pend       <= cordic_in ^ 12'h575;
      cordic_out <= 12'hFFF;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) cordic_out <= pend;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    d   = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_irq(input int maxc, output int c, output logic ok);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (irq) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  logic        err;
  logic        ok;
  int          c1, c2, w0;

  initial begin
    // Reset state
    reset_dut();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_cordic_wr", 32'(cordic_wr), 32'd0);
    check("rst_cordic_in", 32'(cordic_in), 32'd0);
    check("rst_pready", 32'(pready), 32'd1);
    apb_read(8'h08, rd, err);
    check("rst_status", rd, 32'h02);
    apb_read(8'h00, rd, err);
    check("rst_ctrl", rd, 32'h00);
    apb_read(8'h04, rd, err);
    check("rst_period", rd, 32'h00);

    // Single START with interrupt enabled: latency and irq timing
    adc_data = 12'h123;
    w0 = wr_cnt;
    apb_write(8'h00, 32'h6);
    @(posedge clk); #1;
    check("start_wr_pulse", 32'(cordic_wr), 32'd1);
    check("start_cordic_in", 32'(cordic_in), 32'h123);
    adc_data = 12'h7AA;
    @(posedge clk); #1;
    check("start_wr_low", 32'(cordic_wr), 32'd0);
    check("cordic_in_hold", 32'(cordic_in), 32'h123);
    repeat (LAT) @(posedge clk);
    #1;
    check("irq_before_push", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("irq_after_push", 32'(irq), 32'd1);
    check("wr_pulse_count", 32'(wr_cnt - w0), 32'd1);
    apb_read(8'h08, rd, err);
    check("start_status", rd, 32'h20);
    apb_read(8'h0C, rd, err);
    check("start_result", rd, 32'h01230456);
    check("irq_after_read", 32'(irq), 32'd0);
    apb_read(8'h08, rd, err);
    check("start_status_empty", rd, 32'h02);

    // Periodic run at PERIOD=40
    adc_data = 12'h123;
    apb_write(8'h04, 32'd40);
    apb_write(8'h00, 32'h5);
    wait_irq(80, c1, ok);
    check("per_irq1_seen", 32'(ok), 32'd1);
    apb_read(8'h0C, rd, err);
    check("per_result1", rd, 32'h01230456);
    apb_read(8'h08, rd, err);
    check("per_status1", rd, 32'h02);
    wait_irq(60, c2, ok);
    check("per_irq2_seen", 32'(ok), 32'd1);
    check("per_gap", 32'(c2 - c1), 32'd40);
    apb_read(8'h0C, rd, err);
    check("per_result2", rd, 32'h01230456);
    apb_write(8'h00, 32'h4);
    repeat (60) @(posedge clk);
    apb_read(8'h08, rd, err);
    check("per_stopped_status", rd, 32'h02);

    // Miss: PERIOD=5 is shorter than a conversion; EN cleared while the second one is in flight
    reset_dut();
    adc_data = 12'h123;
    apb_write(8'h04, 32'd5);
    apb_write(8'h00, 32'h1);
    repeat (30) @(posedge clk);
    apb_write(8'h00, 32'h0);
    repeat (40) @(posedge clk);
    apb_read(8'h08, rd, err);
    check("miss_status", rd, 32'h50);
    apb_write(8'h08, 32'h10);
    apb_read(8'h08, rd, err);
    check("miss_cleared", rd, 32'h40);
    apb_read(8'h0C, rd, err);
    check("miss_result1", rd, 32'h01230456);
    apb_read(8'h0C, rd, err);
    check("miss_result2", rd, 32'h01230456);
    apb_read(8'h08, rd, err);
    check("miss_drained", rd, 32'h02);

    // Overflow: fill, then push+pop while full, then push while full
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      adc_data = 12'h100 + 12'(i);
      apb_write(8'h00, 32'h2);
      repeat (25) @(posedge clk);
    end
    apb_read(8'h08, rd, err);
    check("ovf_full_status", rd, 32'h84);
    adc_data = 12'h104;
    apb_write(8'h00, 32'h2);
    repeat (LAT) @(posedge clk);
    apb_read(8'h0C, rd, err);
    check("ovf_same_cycle_pop", rd, 32'h01000475);
    repeat (5) @(posedge clk);
    apb_read(8'h08, rd, err);
    check("ovf_same_cycle_status", rd, 32'h84);
    adc_data = 12'h105;
    apb_write(8'h00, 32'h2);
    repeat (25) @(posedge clk);
    apb_read(8'h08, rd, err);
    check("ovf_set_status", rd, 32'h8C);
    apb_read(8'h0C, rd, err);
    check("ovf_entry1", rd, 32'h01010474);
    apb_read(8'h0C, rd, err);
    check("ovf_entry2", rd, 32'h01020477);
    apb_read(8'h0C, rd, err);
    check("ovf_entry3", rd, 32'h01030476);
    apb_read(8'h0C, rd, err);
    check("ovf_entry4", rd, 32'h01040471);
    apb_read(8'h0C, rd, err);
    check("ovf_empty_read", rd, 32'h0);
    apb_read(8'h08, rd, err);
    check("ovf_after_drain", rd, 32'h0A);
    apb_write(8'h08, 32'h08);
    apb_read(8'h08, rd, err);
    check("ovf_cleared", rd, 32'h02);

    // Abort: reset during WAIT discards the conversion
    reset_dut();
    adc_data = 12'h2AB;
    apb_write(8'h00, 32'h2);
    repeat (5) @(posedge clk);
    #1;
    w0 = wr_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_cordic_in", 32'(cordic_in), 32'd0);
    apb_read(8'h08, rd, err);
    check("abort_idle", rd, 32'h02);
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_wr", 32'(wr_cnt - w0), 32'd0);
    apb_read(8'h08, rd, err);
    check("abort_no_push", rd, 32'h02);

    // Address decode
    apb_read(8'h10, rd, err);
    check("decode_err_unmapped", 32'(err), 32'd1);
    check("decode_data_unmapped", rd, 32'd0);
    apb_read(8'h0C, rd, err);
    check("decode_err_mapped", 32'(err), 32'd0);
    apb_write(8'h14, 32'h1234);
    apb_read(8'h04, rd, err);
    check("decode_no_alias_write", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
